// File: rtl/mult_div_unit_pkg.sv
// Shared op codes, state encoding and the combinational mul/div result function
// for the execute-stage multiply/divide unit.
package mult_div_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } md_state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;
  } md_res_t;

  function automatic logic is_long_op(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  function automatic logic is_mult_op(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd2);
  endfunction

  // Divisor is forced to 1 on divide-by-zero so the operators stay defined;
  // the wr flag then suppresses the HI/LO update at commit.
  function automatic md_res_t md_compute(input logic [2:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    md_res_t            res;
    logic [63:0]        p;
    logic signed [32:0] sa, sb, q, r;
    logic [31:0]        ub;
    res = '0;
    p   = '0;
    sa  = '0;
    sb  = '0;
    q   = '0;
    r   = '0;
    ub  = (b == 32'd0) ? 32'd1 : b;
    case (op)
      3'd1: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        res = '{hi: p[63:32], lo: p[31:0], wr: 1'b1};
      end
      3'd2: begin
        p = {32'd0, a} * {32'd0, b};
        res = '{hi: p[63:32], lo: p[31:0], wr: 1'b1};
      end
      3'd3: begin
        // 33-bit signed math keeps 0x80000000 / -1 from overflowing.
        sa = {a[31], a};
        sb = (b == 32'd0) ? 33'sd1 : {b[31], b};
        q  = sa / sb;
        r  = sa % sb;
        res = '{hi: r[31:0], lo: q[31:0], wr: (b != 32'd0)};
      end
      3'd4: begin
        res = '{hi: a % ub, lo: a / ub, wr: (b != 32'd0)};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit owning HI/LO: fixed-latency mult/div with busy
// flag for the stall logic, single-cycle mthi/mtlo writes.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_mdOp,
  input  logic        E_start,
  input  logic        E_req,
  input  logic [31:0] E_src1,
  input  logic [31:0] E_src2,
  output logic        E_busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  md_state_e   state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, commit;
  md_res_t     res, res_lat;
  logic [31:0] hi_q, lo_q;

  assign res = md_compute(E_mdOp, E_src1, E_src2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (E_start && !E_req && is_long_op(E_mdOp)) begin
          accept    = 1'b1;
          state_nxt = ST_BUSY;
          cnt_nxt   = is_mult_op(E_mdOp) ? MULT_LD : DIV_LD;
        end
      end
      ST_BUSY: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_lat <= '0;
    end else if (accept) begin
      res_lat <= res;
    end
  end

  // Only one of commit / mthi / mtlo can fire: the moves require IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (commit) begin
      if (res_lat.wr) begin
        hi_q <= res_lat.hi;
        lo_q <= res_lat.lo;
      end
    end else if (state == ST_IDLE && !E_req) begin
      if (E_mdOp == 3'd5) hi_q <= E_src1;
      if (E_mdOp == 3'd6) lo_q <= E_src1;
    end
  end

  assign E_busy = (state == ST_BUSY);
  assign E_HI   = hi_q;
  assign E_LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed test-plan cases plus randomized traffic
// compared every cycle against a cycle-count/arithmetic model of HI/LO.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  op;
  logic        start, req;
  logic [31:0] src1, src2;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model state: architectural HI/LO, cycles of busy left, pending result.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pwr;
  int          m_rem;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(rst_n), .E_mdOp(op), .E_start(start), .E_req(req),
    .E_src1(src1), .E_src2(src2), .E_busy(busy), .E_HI(hi), .E_LO(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pwr = 0; m_rem = 0;
  endtask

  task automatic model_edge(input logic [2:0] o, input bit s, input bit r,
                            input logic [31:0] a, input logic [31:0] b);
    int              sa, sb;
    longint          ps;
    longint unsigned pu;
    sa = a;
    sb = b;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_pwr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (!r) begin
      if (s && o >= 1 && o <= 4) begin
        m_pwr = 1;
        case (o)
          3'd1: begin ps = longint'(sa) * longint'(sb); m_phi = ps[63:32]; m_plo = ps[31:0]; end
          3'd2: begin pu = {32'd0, a} * {32'd0, b}; m_phi = pu[63:32]; m_plo = pu[31:0]; end
          3'd3: begin
            if (sb == 0) m_pwr = 0;
            else begin
              ps = longint'(sa) / longint'(sb); m_plo = ps[31:0];
              ps = longint'(sa) % longint'(sb); m_phi = ps[31:0];
            end
          end
          default: begin
            if (b == 0) m_pwr = 0;
            else begin m_plo = a / b; m_phi = a % b; end
          end
        endcase
        m_rem = (o <= 2) ? 5 : 10;
      end
      if (o == 3'd5) m_hi = a;
      if (o == 3'd6) m_lo = a;
    end
  endtask

  task automatic cyc(input logic [2:0] o, input bit s, input bit r,
                     input logic [31:0] a, input logic [31:0] b);
    op = o; start = s; req = r; src1 = a; src2 = b;
    @(posedge clk);
    model_edge(o, s, r, a, b);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  initial begin
    int n;
    logic [2:0] ro;
    bit rs, rr;
    rst_n = 1'b0; op = 0; start = 0; req = 0; src1 = 0; src2 = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    cyc(3'd1, 1, 0, 32'hFFFFFFFD, 32'd5);
    n = 0;
    for (int i = 0; i < 20 && busy; i++) begin n++; idle(1); end
    check("mult_busy_len", n, 32'd5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFF1);

    cyc(3'd2, 1, 0, 32'hFFFFFFFF, 32'd2);
    idle(5);
    check("multu_hi", hi, 32'h00000001);
    check("multu_lo", lo, 32'hFFFFFFFE);

    cyc(3'd3, 1, 0, 32'hFFFFFFF9, 32'd2);
    idle(10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    cyc(3'd3, 1, 0, 32'h80000000, 32'hFFFFFFFF);
    idle(10);
    check("divovf_lo", lo, 32'h80000000);
    check("divovf_hi", hi, 32'h00000000);

    cyc(3'd5, 0, 0, 32'h11, 32'd0);
    cyc(3'd6, 0, 0, 32'h22, 32'd0);
    cyc(3'd4, 1, 0, 32'd7, 32'd0);
    n = 0;
    for (int i = 0; i < 20 && busy; i++) begin n++; idle(1); end
    check("divu0_busy_len", n, 32'd10);
    check("divu0_hi", hi, 32'h11);
    check("divu0_lo", lo, 32'h22);

    cyc(3'd5, 0, 1, 32'hABCD, 32'd0);
    check("mthi_req_hi", hi, 32'h11);
    cyc(3'd5, 0, 0, 32'hABCD, 32'd0);
    check("mthi_hi", hi, 32'hABCD);
    check("mthi_busy", {31'd0, busy}, 32'd0);

    cyc(3'd1, 1, 0, 32'd7, 32'd6);
    idle(1);
    cyc(3'd0, 0, 1, 32'd0, 32'd0);
    idle(3);
    check("req_busy_done", {31'd0, busy}, 32'd0);
    check("req_lo", lo, 32'd42);
    check("req_hi", hi, 32'd0);

    cyc(3'd1, 1, 0, 32'd3, 32'd3);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    check("midrst_nocommit_lo", lo, 32'd0);

    for (int i = 0; i < 600; i++) begin
      ro = 3'($urandom_range(0, 6));
      rs = (ro >= 1 && ro <= 4) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 7) == 0);
      if ((m_rem > 0) && ($urandom_range(0, 7) != 0)) begin
        ro = 3'd0; rs = 1'b0;
      end
      cyc(ro, rs, rr, rnd_operand(), rnd_operand());
    end
    idle(12);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
